// File: rtl/riscv151_pkg.sv
// Shared RV32I encodings and decode enums for the riscv_151 core.
package riscv151_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    case (f3)
      F3_ADD_SUB: alu_decode = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_decode = ALU_SLL;
      F3_SLT:     alu_decode = ALU_SLT;
      F3_SLTU:    alu_decode = ALU_SLTU;
      F3_XOR:     alu_decode = ALU_XOR;
      F3_SR:      alu_decode = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_decode = ALU_OR;
      default:    alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_151_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != '0) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : registers[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : registers[raddr2];

endmodule

// File: rtl/riscv_151.sv
// Single-cycle RV32I core: inline decode, immediate generation, ALU and imem/dmem; one instruction per clock.
module riscv_151
  import riscv151_pkg::*;
#(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned MEM_WORDS      = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic FPGA_SERIAL_RX,
  output logic FPGA_SERIAL_TX
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] pc, pc_next, pc_plus4, inst, imm, rs1_val, rs2_val;
  logic [31:0] alu_a, alu_b, alu_out, rd_val, dmem_rdata, ld_shift, ld_val, st_data;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [3:0]  st_be;
  logic        rf_we, mem_we, is_branch, is_jal, is_jalr, a_pc, b_imm, taken;
  alu_op_t     alu_op;
  imm_t        imm_sel;
  wb_sel_t     wb_sel;

  logic unused_rx;
  assign unused_rx = FPGA_SERIAL_RX ^ (CPU_CLOCK_FREQ == 0);
  assign FPGA_SERIAL_TX = 1'b1;

  if (1) begin : imem
    logic [31:0] mem [0:MEM_WORDS-1];
    assign inst = mem[pc[AW+1:2]];
  end

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    rf_we = 1'b0; mem_we = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    a_pc = 1'b0; b_imm = 1'b0; alu_op = ALU_ADD; imm_sel = IMM_I; wb_sel = WB_ALU;
    case (opcode)
      OP:     begin rf_we = 1'b1; alu_op = alu_decode(f3, inst[30], 1'b1); end
      OP_IMM: begin rf_we = 1'b1; b_imm = 1'b1; alu_op = alu_decode(f3, inst[30], 1'b0); end
      LOAD:   begin rf_we = 1'b1; b_imm = 1'b1; wb_sel = WB_MEM; end
      STORE:  begin mem_we = 1'b1; b_imm = 1'b1; imm_sel = IMM_S; end
      BRANCH: begin is_branch = 1'b1; imm_sel = IMM_B; end
      JAL:    begin rf_we = 1'b1; is_jal = 1'b1; imm_sel = IMM_J; wb_sel = WB_PC4; end
      JALR:   begin rf_we = 1'b1; is_jalr = 1'b1; b_imm = 1'b1; wb_sel = WB_PC4; end
      LUI:    begin rf_we = 1'b1; b_imm = 1'b1; imm_sel = IMM_U; alu_op = ALU_PASS_B; end
      AUIPC:  begin rf_we = 1'b1; a_pc = 1'b1; b_imm = 1'b1; imm_sel = IMM_U; end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  reg_file rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (inst[11:7]),
    .wdata  (rd_val),
    .raddr1 (inst[19:15]),
    .raddr2 (inst[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign alu_a = a_pc ? pc : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;

  always_comb begin
    case (alu_op)
      ALU_SUB:    alu_out = alu_a - alu_b;
      ALU_SLL:    alu_out = alu_a << alu_b[4:0];
      ALU_SLT:    alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_out = {31'b0, alu_a < alu_b};
      ALU_XOR:    alu_out = alu_a ^ alu_b;
      ALU_SRL:    alu_out = alu_a >> alu_b[4:0];
      ALU_SRA:    alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:     alu_out = alu_a | alu_b;
      ALU_AND:    alu_out = alu_a & alu_b;
      ALU_PASS_B: alu_out = alu_b;
      default:    alu_out = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val < rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (is_jal || (is_branch && taken)) pc_next = pc + imm;
    else if (is_jalr)                   pc_next = alu_out & ~32'd1;
    else                                pc_next = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

  // Word-addressed dmem; sub-word offsets only steer lanes, so misaligned accesses wrap within the word.
  always_comb begin
    case (f3)
      F3_B:    st_be = 4'b0001 << alu_out[1:0];
      F3_H:    st_be = alu_out[1] ? 4'b1100 : 4'b0011;
      F3_W:    st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    case (f3)
      F3_B:    st_data = {4{rs2_val[7:0]}};
      F3_H:    st_data = {2{rs2_val[15:0]}};
      default: st_data = rs2_val;
    endcase
  end

  if (1) begin : dmem
    logic [31:0] mem [0:MEM_WORDS-1];
    always_ff @(posedge clk) begin
      if (rst && mem_we) begin
        for (int unsigned b = 0; b < 4; b++)
          if (st_be[b]) mem[alu_out[AW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    assign dmem_rdata = mem[alu_out[AW+1:2]];
  end

  assign ld_shift = dmem_rdata >> {alu_out[1:0], 3'b000};

  always_comb begin
    case (f3)
      F3_B:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_val = {24'b0, ld_shift[7:0]};
      F3_H:    ld_val = alu_out[1] ? {{16{dmem_rdata[31]}}, dmem_rdata[31:16]}
                                   : {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      F3_HU:   ld_val = alu_out[1] ? {16'b0, dmem_rdata[31:16]} : {16'b0, dmem_rdata[15:0]};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  rd_val = ld_val;
      WB_PC4:  rd_val = pc_plus4;
      default: rd_val = alu_out;
    endcase
  end

endmodule

// File: tb/tb_riscv_151.sv
// Directed program bench for riscv_151: assembles a test program into imem and checks architectural state per step.
module tb_riscv_151;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] prog [$];
  logic [31:0] acc;

  riscv_151 #(
    .CPU_CLOCK_FREQ (50_000_000),
    .RESET_PC       (32'h0000_0000),
    .MEM_WORDS      (4096)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .FPGA_SERIAL_RX (rx),
    .FPGA_SERIAL_TX (tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic regs_or(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 32; i++) v |= dut.rf.registers[i];
  endtask

  function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, rd, op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  localparam logic [31:0] OPI = 32'h13, LD = 32'h03, JR = 32'h67, LU = 32'h37;

  initial begin
    prog.push_back(enc_i(5, 0, 0, 1, OPI));          // 0  addi x1,x0,5
    prog.push_back(enc_i(100, 0, 0, 2, OPI));        // 1
    prog.push_back(enc_i(200, 0, 0, 3, OPI));        // 2
    prog.push_back(enc_r(0, 3, 2, 0, 1));            // 3  add x1,x2,x3
    prog.push_back(enc_i(1, 0, 0, 20, OPI));         // 4  addi x20,x0,1
    prog.push_back(enc_i(32'h6C, 0, 0, 2, OPI));     // 5
    prog.push_back(enc_i(32'hC0, 0, 0, 3, OPI));     // 6
    prog.push_back(enc_r(0, 3, 2, 7, 1));            // 7  and
    prog.push_back(enc_r(0, 3, 2, 6, 1));            // 8  or
    prog.push_back(enc_r(0, 3, 2, 4, 1));            // 9  xor
    prog.push_back(enc_u(32'h80000, 4, LU));         // 10 lui x4
    prog.push_back(enc_i(1, 0, 0, 5, OPI));          // 11 x5=1
    prog.push_back(enc_r(0, 5, 4, 1, 1));            // 12 sll x1,x4,x5
    prog.push_back(enc_i(-1, 0, 0, 6, OPI));         // 13 x6=-1
    prog.push_back(enc_r(0, 5, 6, 2, 1));            // 14 slt
    prog.push_back(enc_r(0, 5, 6, 3, 1));            // 15 sltu
    prog.push_back(enc_i(32'h3E, 0, 0, 7, OPI));     // 16 x7=0x3E
    prog.push_back(enc_r(0, 5, 7, 5, 1));            // 17 srl
    prog.push_back(enc_r(32'h20, 5, 7, 5, 1));       // 18 sra
    prog.push_back(enc_i(32'h404, 4, 5, 1, OPI));    // 19 srai x1,x4,4
    prog.push_back(enc_i(7, 0, 0, 0, OPI));          // 20 addi x0,x0,7
    prog.push_back(enc_i(3, 0, 0, 8, OPI));          // 21 addi x8,x0,3
    prog.push_back(enc_b(8, 5, 5, 0));               // 22 beq x5,x5,+8
    prog.push_back(enc_i(1, 0, 0, 9, OPI));          // 23 skipped
    prog.push_back(enc_i(2, 0, 0, 10, OPI));         // 24
    prog.push_back(enc_j(8, 11));                    // 25 jal x11,+8
    prog.push_back(enc_i(1, 0, 0, 12, OPI));         // 26 skipped
    prog.push_back(enc_i(121, 0, 0, 13, OPI));       // 27 x13=121
    prog.push_back(enc_i(0, 13, 0, 14, JR));         // 28 jalr x14,0(x13)
    prog.push_back(enc_i(3, 0, 0, 12, OPI));         // 29 skipped
    prog.push_back(enc_i(4, 0, 0, 15, OPI));         // 30
    prog.push_back(enc_u(32'hDEADC, 16, LU));        // 31
    prog.push_back(enc_i(-273, 16, 0, 16, OPI));     // 32 x16=0xDEADBEEF
    prog.push_back(enc_s(32'h100, 16, 0, 2));        // 33 sw
    prog.push_back(enc_i(32'h100, 0, 0, 1, LD));     // 34 lb
    prog.push_back(enc_i(32'h103, 0, 4, 1, LD));     // 35 lbu
    prog.push_back(enc_i(32'h11, 0, 0, 17, OPI));    // 36
    prog.push_back(enc_s(32'h101, 17, 0, 0));        // 37 sb
    prog.push_back(enc_i(32'h100, 0, 2, 1, LD));     // 38 lw
    prog.push_back(enc_i(32'h102, 0, 1, 1, LD));     // 39 lh
    prog.push_back(enc_j(0, 0));                     // 40 jal x0,0

    for (int i = 0; i < 4096; i++)
      dut.imem.mem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;

    #2 rst = 1'b0;
    #1;
    check_eq("reset_pc", dut.pc, 32'h0);
    regs_or(acc);
    check_eq("reset_regs", acc, 32'h0);
    check_eq("serial_tx_idle", {31'b0, tx}, 32'h1);
    @(negedge clk) rst = 1'b1;

    step(1);  check_eq("first_addi", dut.rf.registers[1], 32'd5);
              check_eq("pc_after_first", dut.pc, 32'd4);
    step(3);  check_eq("add", dut.rf.registers[1], 32'd300);
    step(1);  check_eq("x20", dut.rf.registers[20], 32'd1);
    step(3);  check_eq("and", dut.rf.registers[1], 32'h40);
    step(1);  check_eq("or", dut.rf.registers[1], 32'hEC);
    step(1);  check_eq("xor", dut.rf.registers[1], 32'hAC);
    step(3);  check_eq("lui", dut.rf.registers[4], 32'h8000_0000);
              check_eq("sll_wrap", dut.rf.registers[1], 32'h0);
    step(2);  check_eq("slt", dut.rf.registers[1], 32'h1);
    step(1);  check_eq("sltu", dut.rf.registers[1], 32'h0);
    step(2);  check_eq("srl", dut.rf.registers[1], 32'h1F);
    step(1);  check_eq("sra_pos", dut.rf.registers[1], 32'h1F);
    step(1);  check_eq("srai_neg", dut.rf.registers[1], 32'hF800_0000);
    step(2);  check_eq("x0_zero", dut.rf.registers[0], 32'h0);
              check_eq("x0_reads_0", dut.rf.registers[8], 32'd3);
    step(2);  check_eq("beq_skip", dut.rf.registers[9], 32'h0);
              check_eq("beq_target", dut.rf.registers[10], 32'd2);
              check_eq("pc_after_beq", dut.pc, 32'd100);
    step(1);  check_eq("jal_link", dut.rf.registers[11], 32'd104);
              check_eq("jal_pc", dut.pc, 32'd108);
    step(2);  check_eq("jalr_link", dut.rf.registers[14], 32'd116);
              check_eq("jalr_pc_bit0", dut.pc, 32'd120);
    step(1);  check_eq("jalr_skip", dut.rf.registers[12], 32'h0);
              check_eq("jalr_target", dut.rf.registers[15], 32'd4);
    step(3);  check_eq("x16", dut.rf.registers[16], 32'hDEAD_BEEF);
              check_eq("sw_mem", dut.dmem.mem[64], 32'hDEAD_BEEF);
    step(1);  check_eq("lb", dut.rf.registers[1], 32'hFFFF_FFEF);
    step(1);  check_eq("lbu", dut.rf.registers[1], 32'h0000_00DE);
    step(3);  check_eq("sb_lw", dut.rf.registers[1], 32'hDEAD_11EF);
    step(1);  check_eq("lh_upper", dut.rf.registers[1], 32'hFFFF_DEAD);
    step(3);  check_eq("loop_pc", dut.pc, 32'd160);

    #3 rst = 1'b0;
    #1;
    check_eq("async_reset_pc", dut.pc, 32'h0);
    regs_or(acc);
    check_eq("async_reset_regs", acc, 32'h0);
    check_eq("dmem_kept", dut.dmem.mem[64], 32'hDEAD_11EF);
    step(1);
    check_eq("held_reset_pc", dut.pc, 32'h0);
    check_eq("held_reset_x1", dut.rf.registers[1], 32'h0);
    @(negedge clk) rst = 1'b1;
    step(1);  check_eq("restart_addi", dut.rf.registers[1], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_151.md
# riscv_151

Single-cycle RV32I integer core used as the top-level CPU of the 151 FPGA project. It fetches from an on-chip instruction memory, executes one instruction per clock, and writes results to a 32×32 register file. It is the block that the assembly-level test programs (R-type, I-type, branch, load/store) execute on. The serial port is reserved for a later UART MMIO block and is idle in this revision.

## Interface
- CPU_CLOCK_FREQ, 50_000_000, core clock in Hz; reserved for UART baud generation, no effect on this revision
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MEM_WORDS, 4096, depth in 32-bit words of both imem and dmem
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  reset; asynchronous and active-low
- FPGA_SERIAL_RX  input  1  serial receive; ignored
- FPGA_SERIAL_TX  output  1  serial transmit; driven constant 1 (line idle)

## Operation
- Hierarchy: register file instance `rf`, storage array `registers[0:31]`; instruction memory instance `imem`, array `mem[0:MEM_WORDS-1]` loadable by $readmemh; data memory instance `dmem`, array `mem`.
- Fetch: instruction = imem.mem[PC[log2(MEM_WORDS)+1:2]]; PC[1:0] ignored.
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- Any other opcode (FENCE, ECALL, CSR, illegal): NOP, PC+4.
- Arithmetic: 32-bit wrap-around, no overflow trap; shift amount = rs2[4:0] or shamt; SLT signed, SLTU unsigned; SRA sign-fills.
- Immediates sign-extended per RV32I I/S/B/U/J formats.
- Register file: 2 combinational read ports, 1 synchronous write port; x0 reads 0 and writes to it are discarded.
- Next PC: PC+4; branch taken → PC+immB; JAL → PC+immJ; JALR → (rs1+immI) & ~1; rd of JAL/JALR gets PC+4.
- Loads: byte/half extracted by address[1:0], sign- or zero-extended; combinational read. Stores: byte-enable write of addressed lanes, other lanes preserved.
- Misaligned halfword/word accesses: address[1:0] ignored for LW/SW, address[0] ignored for LH/SH; no exception.

## Timing
- Reset asserted (rst=0): PC ← RESET_PC and all 32 registers ← 0 immediately, independent of clk; dmem/imem contents untouched.
- First instruction (at RESET_PC) commits on the first rising edge after rst returns to 1.
- Every instruction commits in exactly 1 cycle: rd, dmem store and PC update all on the same rising edge; CPI = 1, no stalls, no hazards.
- Reset mid-program: in-flight instruction is discarded, no write occurs on that edge.
- Instruction writing the same register it reads: reads old value, new value visible next cycle.

## Structure
- Package `riscv151_pkg`: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), funct3 constants, ALU-operation enum, immediate-type enum.
- One natural sub-module: `reg_file` (instance `rf`). ALU, immediate generator, decoder and memories stay inline in the top.

## Test plan
- Reset: rst low 1 cycle with program loaded → PC=0, all registers 0; after release x1 updated on first edge by `addi x1,x0,5` → x1=5.
- ADD: x2=100, x3=200, `add x1,x2,x3` → x1=300; then x20=1.
- Logic: x2=0x6C, x3=0xC0 → AND x1=0x40, OR x1=0xEC, XOR x1=0xAC.
- Shifts/compares: SLL 0x80000000<<1 → 0; SLT −1,1 → 1; SLTU 0xFFFFFFFF,1 → 0; SRL 0x3E>>1 → 0x1F; SRA 0x3E>>1 → 0x1F; SRA 0x80000000>>4 → 0xF8000000.
- x0 and control flow: `addi x0,x0,7` → x0 reads 0; BEQ taken skips next instruction; JAL writes PC+4 to rd; JALR target bit 0 cleared.
- Memory: `sw` 0xDEADBEEF to addr 0x100, `lb` 0x100 → 0xFFFFFFEF, `lbu` 0x103 → 0xDE, `sb` 0x11 to 0x101 then `lw` → 0xDEAD11EF.
